pwm_multi_ch: RTL and testbench
===============================

# pwm_multi_ch

Multi-channel PWM generator with a shared programmable-period counter, edge- or center-aligned modulation and glitch-free double-buffered duty/period/mode updates. It drives LED/motor-driver enables from a single clock domain. Register-bank logic writes new settings at any time, and the block applies them only at a period boundary.

## Interface
Parameters:
- CBITS, 18, counter, period and duty width
- NCH, 3, number of PWM channels

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run enable; low holds counter and outputs idle
- period  in  CBITS  period value P (shadowed)
- center  in  1  mode request: 0 = edge-aligned, 1 = center-aligned (shadowed)
- duty  in  NCH*CBITS  duty value per channel; channel i in bits [i*CBITS +: CBITS]
- upd_we  in  1  one-cycle strobe; captures period, center and duty into shadow registers
- pwm_out  out  NCH  registered PWM outputs
- cyc_start  out  1  one-cycle pulse in the cycle the counter is at a period boundary
- upd_ack  out  1  one-cycle pulse when a pending shadow set is transferred to the active set

## Operation
- State: counter cnt[CBITS-1:0], direction dir (UP/DOWN), active set (P_act, mode_act, duty_act[i]), shadow set, pending flag.
- Edge mode: cnt counts 0..P_act, then wraps to 0. The period length is P_act+1 clocks. dir stays UP.
- Center mode: cnt counts up 0..P_act with dir=UP, then down P_act-1..1 with dir=DOWN, then returns to 0 with dir=UP. The period length is 2·P_act clocks.
- P_act = 0 in either mode: cnt stays at 0 and every cycle is a boundary.
- Boundary: the cycle in which cnt = 0 with dir=UP while en=1.
- Compare: channel output is high when cnt < duty_act[i], unsigned and full width.
  - duty 0 keeps the output always low.
  - duty > P_act keeps the output always high in both modes.
- Update: upd_we copies the inputs into the shadow set and sets pending.
  - At a boundary with pending=1, shadow moves to active, pending clears and upd_ack pulses.
  - If upd_we coincides with a boundary, the newly written values are the ones transferred in that same edge.
  - Repeated upd_we before a boundary: the last write wins.
- en low: cnt is forced to 0 and dir to UP, pwm_out is forced to 0, and cyc_start and upd_ack stay 0. Shadow capture still works.
- en rising: the first enabled cycle is a boundary, so any pending update applies immediately.
- A mode or period change never takes effect mid-period. The cnt sequence restarts from 0 under the new settings.

## Timing
- Reset (rst_n low, asynchronous): cnt=0, dir=UP, all active/shadow registers 0, mode_act=edge, pending=0, pwm_out=0, cyc_start=0, upd_ack=0.
- pwm_out[i] at edge t+1 = (cnt(t) < duty_act(t)) && en(t). This is one cycle of latency.
- cyc_start and upd_ack are registered and assert one cycle after the boundary cycle. They are aligned with the first pwm_out value of the new period.
- The active set updates on the boundary edge, so the compare in the following cycle uses the new values.
- Reset release mid-period or rst_n assertion at any time aborts the current period; operation restarts from the reset state.

## Structure
- Package pwm_pkg holds:
  - typedef pwm_mode_e {PWM_EDGE, PWM_CENTER}
  - typedef pwm_dir_e {DIR_UP, DIR_DOWN}
  - the reset constants
- Top module contains the shared counter/direction state machine, the period/mode shadow registers, the pending flag and the strobes.
- Sub-module pwm_cmp_ch, instantiated NCH times, contains the duty shadow and active registers, the comparator and the output flop. Its load enables come from the top.

## Test plan
- CBITS=8, NCH=3, edge, P=9, duty={0,5,12}, upd_we then en=1. Expected: period 10 clocks; ch0 always low, ch1 high for 5 of 10 clocks, ch2 always high; cyc_start every 10 clocks.
- Center, P=4, duty ch1=2. Expected: cnt sequence 0,1,2,3,4,3,2,1 repeating; ch1 high 3 of 8 clocks, symmetric around cnt=0.
- Mid-period upd_we changing duty 5→2 at cnt=3. Expected: no change until the boundary; upd_ack one cycle after the boundary; the next period shows the new duty with no runt pulse.
- upd_we asserted exactly in the boundary cycle. Expected: the new values apply in that same period and upd_ack pulses once.
- en dropped at cnt=6. Expected: pwm_out low the next cycle. After en returns, pending updates apply in the first cycle and cnt restarts at 0.
- rst_n asserted mid-period, asynchronously between edges. Expected: all outputs 0 immediately; after release with en=1, active duties are 0 and outputs stay low until an update is applied.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and reset constants for the multi-channel PWM generator.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    localparam pwm_mode_e MODE_RST = PWM_EDGE;
    localparam pwm_dir_e  DIR_RST  = DIR_UP;
    localparam logic      PEND_RST = 1'b0;
    localparam logic      OUT_RST  = 1'b0;

endpackage

// File: rtl/pwm_cmp_ch.sv
// One PWM channel: duty shadow/active registers, comparator and output flop.
module pwm_cmp_ch
    import pwm_pkg::*;
#(
    parameter int unsigned CBITS = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CBITS-1:0] cnt,
    input  logic [CBITS-1:0] duty,
    input  logic             sh_we,
    input  logic             act_we,
    output logic             pwm
);

    logic [CBITS-1:0] duty_sh_q;
    logic [CBITS-1:0] duty_act_q, duty_act_d;
    logic             pwm_q, pwm_d;

    always_comb begin
        duty_act_d = duty_act_q;
        // A write landing on the boundary edge bypasses the shadow.
        if (act_we) begin
            duty_act_d = sh_we ? duty : duty_sh_q;
        end
        pwm_d = en && (cnt < duty_act_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_sh_q  <= '0;
            duty_act_q <= '0;
            pwm_q      <= OUT_RST;
        end else begin
            if (sh_we) begin
                duty_sh_q <= duty;
            end
            duty_act_q <= duty_act_d;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: shared edge/center counter, double-buffered settings applied
// only at a period boundary.
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int unsigned CBITS = 18,
    parameter int unsigned NCH   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [CBITS-1:0]     period,
    input  logic                 center,
    input  logic [NCH*CBITS-1:0] duty,
    input  logic                 upd_we,
    output logic [NCH-1:0]       pwm_out,
    output logic                 cyc_start,
    output logic                 upd_ack
);

    logic [CBITS-1:0] cnt_q, cnt_d;
    pwm_dir_e         dir_q, dir_d;
    logic [CBITS-1:0] period_act_q, period_sh_q, period_eff;
    pwm_mode_e        mode_act_q, mode_sh_q, mode_eff;
    logic             pending_q;
    logic             cyc_start_q, upd_ack_q;
    logic             boundary, apply;

    assign boundary = en && (cnt_q == '0) && (dir_q == DIR_UP);
    assign apply    = boundary && (pending_q || upd_we);

    always_comb begin
        period_eff = period_act_q;
        mode_eff   = mode_act_q;
        // The step out of a boundary already follows the incoming settings.
        if (apply) begin
            period_eff = upd_we ? period : period_sh_q;
            mode_eff   = upd_we ? pwm_mode_e'(center) : mode_sh_q;
        end

        cnt_d = '0;
        dir_d = DIR_UP;
        if (en && (period_eff != '0)) begin
            if (mode_eff == PWM_EDGE) begin
                cnt_d = (cnt_q >= period_eff) ? '0 : cnt_q + CBITS'(1);
            end else if (dir_q == DIR_UP) begin
                if (cnt_q >= period_eff) begin
                    cnt_d = cnt_q - CBITS'(1);
                    dir_d = (cnt_d == '0) ? DIR_UP : DIR_DOWN;
                end else begin
                    cnt_d = cnt_q + CBITS'(1);
                end
            end else begin
                if (cnt_q > CBITS'(1)) begin
                    cnt_d = cnt_q - CBITS'(1);
                    dir_d = DIR_DOWN;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            dir_q        <= DIR_RST;
            period_act_q <= '0;
            period_sh_q  <= '0;
            mode_act_q   <= MODE_RST;
            mode_sh_q    <= MODE_RST;
            pending_q    <= PEND_RST;
            cyc_start_q  <= 1'b0;
            upd_ack_q    <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            if (upd_we) begin
                period_sh_q <= period;
                mode_sh_q   <= pwm_mode_e'(center);
            end
            if (apply) begin
                period_act_q <= period_eff;
                mode_act_q   <= mode_eff;
                pending_q    <= 1'b0;
            end else if (upd_we) begin
                pending_q <= 1'b1;
            end
            cyc_start_q <= boundary;
            upd_ack_q   <= apply;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : gen_ch
        pwm_cmp_ch #(
            .CBITS (CBITS)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en),
            .cnt    (cnt_q),
            .duty   (duty[i*CBITS +: CBITS]),
            .sh_we  (upd_we),
            .act_we (apply),
            .pwm    (pwm_out[i])
        );
    end

    assign cyc_start = cyc_start_q;
    assign upd_ack   = upd_ack_q;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Scoreboard bench for pwm_multi_ch: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_pwm_multi_ch;

    localparam int unsigned CBITS = 8;
    localparam int unsigned NCH   = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 en;
    logic [CBITS-1:0]     period;
    logic                 center;
    logic [NCH*CBITS-1:0] duty;
    logic                 upd_we;
    logic [NCH-1:0]       pwm_out;
    logic                 cyc_start;
    logic                 upd_ack;

    typedef struct {
        int       cyc;
        logic [2:0] pwm;
        logic     cs;
        logic     ack;
        string    name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc_n = 0;
    int   tests = 0;
    int   fails = 0;

    pwm_multi_ch #(
        .CBITS (CBITS),
        .NCH   (NCH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .period    (period),
        .center    (center),
        .duty      (duty),
        .upd_we    (upd_we),
        .pwm_out   (pwm_out),
        .cyc_start (cyc_start),
        .upd_ack   (upd_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic void expect_at(int c, logic [2:0] p, logic cs, logic ack, string name);
        exp_t e;
        e.cyc  = c;
        e.pwm  = p;
        e.cs   = cs;
        e.ack  = ack;
        e.name = name;
        sb.push_back(e);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cycle(int k);
        while (cyc_n < k) step();
    endtask

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc_n) begin
            mon_e = sb.pop_front();
            tests++;
            if (mon_e.cyc != cyc_n || pwm_out !== mon_e.pwm || cyc_start !== mon_e.cs
                || upd_ack !== mon_e.ack) begin
                fails++;
                $display("FAIL %s cycle %0d (due %0d): got pwm=%b cs=%b ack=%b, want pwm=%b cs=%b ack=%b",
                         mon_e.name, cyc_n, mon_e.cyc, pwm_out, cyc_start, upd_ack,
                         mon_e.pwm, mon_e.cs, mon_e.ack);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d expectations pending", sb.size());
        $fatal(1);
    end

    initial begin
        int a, b, d, e, g, r, c;
        int seq[8];
        seq = '{0, 1, 2, 3, 4, 3, 2, 1};

        rst_n  = 1'b0;
        en     = 1'b0;
        period = '0;
        center = 1'b0;
        duty   = '0;
        upd_we = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        r = cyc_n;
        for (int i = 0; i < 3; i++) expect_at(r + i, 3'b000, 1'b0, 1'b0, "reset_idle");

        // Edge mode, P=9, duty {ch2=12, ch1=5, ch0=0}; write while idle, then enable.
        goto_cycle(r + 3);
        a = cyc_n;
        expect_at(a, 3'b000, 1'b0, 1'b0, "edge_pre");
        expect_at(a + 1, 3'b000, 1'b0, 1'b0, "edge_pre");
        expect_at(a + 2, 3'b000, 1'b1, 1'b1, "edge_first_boundary");
        for (int m = 1; m <= 29; m++) begin
            c = m % 10;
            expect_at(a + 2 + m, {1'b1, c < 5, 1'b0}, c == 0, 1'b0, "edge_p9");
        end
        period = 8'd9;
        center = 1'b0;
        duty   = {8'd12, 8'd5, 8'd0};
        upd_we = 1'b1;
        step();
        upd_we = 1'b0;
        en     = 1'b1;
        goto_cycle(a + 31);

        // Center mode P=4, duty {7,2,0}, written exactly in a boundary cycle.
        b = cyc_n;
        expect_at(b + 1, 3'b110, 1'b1, 1'b1, "center_boundary_write");
        for (int j = 1; j <= 23; j++) begin
            c = seq[j % 8];
            expect_at(b + 1 + j, {1'b1, c < 2, 1'b0}, (j % 8) == 0, 1'b0, "center_p4");
        end
        period = 8'd4;
        center = 1'b1;
        duty   = {8'd7, 8'd2, 8'd0};
        upd_we = 1'b1;
        step();
        upd_we = 1'b0;
        goto_cycle(b + 24);

        // Back to edge P=9 duty 5, then mid-period writes 9 and 2 (last wins).
        d = cyc_n;
        expect_at(d + 1, 3'b110, 1'b1, 1'b1, "edge_restore");
        for (int j = 1; j <= 19; j++) begin
            c = j % 10;
            expect_at(d + 1 + j, {1'b1, (j <= 10) ? (c < 5) : (c < 2), 1'b0}, c == 0, j == 10,
                      "mid_update");
        end
        period = 8'd9;
        center = 1'b0;
        duty   = {8'd12, 8'd5, 8'd0};
        upd_we = 1'b1;
        step();
        upd_we = 1'b0;
        goto_cycle(d + 3);
        duty   = {8'd12, 8'd9, 8'd0};
        upd_we = 1'b1;
        step();
        upd_we = 1'b0;
        goto_cycle(d + 5);
        duty   = {8'd12, 8'd2, 8'd0};
        upd_we = 1'b1;
        step();
        upd_we = 1'b0;
        goto_cycle(d + 20);

        // Drop en at cnt=6, write duty 4 while idle, re-enable.
        e = cyc_n;
        for (int j = 0; j <= 5; j++) begin
            expect_at(e + 1 + j, {1'b1, j < 2, 1'b0}, j == 0, 1'b0, "pre_disable");
        end
        for (int j = 7; j <= 10; j++) expect_at(e + j, 3'b000, 1'b0, 1'b0, "disabled");
        expect_at(e + 11, 3'b110, 1'b1, 1'b1, "reenable_apply");
        for (int j = 1; j <= 12; j++) begin
            c = j % 10;
            expect_at(e + 11 + j, {1'b1, c < 4, 1'b0}, c == 0, 1'b0, "after_reenable");
        end
        goto_cycle(e + 6);
        en = 1'b0;
        step();
        duty   = {8'd12, 8'd4, 8'd0};
        upd_we = 1'b1;
        step();
        upd_we = 1'b0;
        goto_cycle(e + 10);
        en = 1'b1;
        goto_cycle(e + 24);

        // Asynchronous reset between edges, then P=0 boundaries, then a fresh update.
        g = cyc_n;
        for (int j = 0; j <= 2; j++) expect_at(g + j, 3'b000, 1'b0, 1'b0, "async_reset");
        for (int j = 3; j <= 7; j++) expect_at(g + j, 3'b000, 1'b1, 1'b0, "p0_boundary");
        expect_at(g + 8, 3'b000, 1'b1, 1'b1, "post_reset_apply");
        for (int j = 1; j <= 8; j++) begin
            c = j % 4;
            expect_at(g + 8 + j, {c < 1, c < 2, 1'b0}, c == 0, 1'b0, "post_reset_p3");
        end
        #2;
        rst_n = 1'b0;
        goto_cycle(g + 2);
        rst_n = 1'b1;
        goto_cycle(g + 7);
        period = 8'd3;
        center = 1'b0;
        duty   = {8'd1, 8'd2, 8'd0};
        upd_we = 1'b1;
        step();
        upd_we = 1'b0;
        goto_cycle(g + 19);

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
